elastic_pipe_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_slot.sv | 59 +++++
 rtl/elastic_pipe_reg.sv | 137 +++++++++++++
 tb/tb_elastic_pipe_reg.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for processor pipeline registers: the D/E control and data
// field layouts that callers cast to/from the elastic_pipe_reg ctrl/data ports.
package pipe_pkg;

  localparam int unsigned DE_CW = 15;
  localparam int unsigned DE_DW = 83;

  typedef struct packed {
    logic       pcload;
    logic       regw;
    logic       memw;
    logic       regmem;
    logic       branch;
    logic       ALUope;
    logic       flag;
    logic [3:0] ALUctrl;
    logic [3:0] regScr;
  } de_ctrl_t;

  typedef struct packed {
    logic [31:0] regA;
    logic [31:0] regB;
    logic [18:0] inm;
  } de_data_t;

endpackage

// File: rtl/pipe_slot.sv
// One elastic pipeline slot: valid bit, control field and data field.
// Flush and non-valid loads clear valid/ctrl but leave data untouched.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned CW = DE_CW,
  parameter int unsigned DW = DE_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          load,
  input  logic          up_valid,
  input  logic [CW-1:0] up_ctrl,
  input  logic [DW-1:0] up_data,
  output logic          valid,
  output logic [CW-1:0] ctrl,
  output logic [DW-1:0] data
);

  logic          valid_q, valid_d;
  logic [CW-1:0] ctrl_q,  ctrl_d;
  logic [DW-1:0] data_q,  data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load) begin
      valid_d = up_valid;
      if (up_valid) begin
        ctrl_d = up_ctrl;
        data_d = up_data;
      end else begin
        ctrl_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign ctrl  = ctrl_q;
  assign data  = data_q;

endmodule

// File: rtl/elastic_pipe_reg.sv
// DEPTH-slot elastic pipeline register with valid/ready stall and flush.
// Optional perf counters (stall_cnt, flush_cnt, clr_cnt) under ELASTIC_PIPE_PERF_EN.
module elastic_pipe_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CW    = DE_CW,
  parameter int unsigned DW    = DE_DW,
  parameter int unsigned DEPTH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CW-1:0]              in_ctrl,
  input  logic [DW-1:0]              in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CW-1:0]              out_ctrl,
  output logic [DW-1:0]              out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef ELASTIC_PIPE_PERF_EN
  ,
  input  logic                       clr_cnt,
  output logic [31:0]                stall_cnt,
  output logic [31:0]                flush_cnt
`endif
);

  localparam int unsigned OW = $clog2(DEPTH+1);

  // Index 0 is the input-side slot, DEPTH-1 the output-side slot.
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] rdy;
  logic [CW-1:0]    s_ctrl [DEPTH];
  logic [DW-1:0]    s_data [DEPTH];

  always_comb begin
    rdy = '0;
    rdy[DEPTH-1] = ~v[DEPTH-1] | out_ready;
    for (int unsigned i = DEPTH-1; i > 0; i--) begin
      rdy[i-1] = ~v[i-1] | rdy[i];
    end
  end

  assign in_ready = rdy[0] & ~flush;

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    logic          up_v;
    logic [CW-1:0] up_c;
    logic [DW-1:0] up_d;

    if (k == 0) begin : g_head
      assign up_v = in_valid;
      assign up_c = in_ctrl;
      assign up_d = in_data;
    end else begin : g_body
      assign up_v = v[k-1];
      assign up_c = s_ctrl[k-1];
      assign up_d = s_data[k-1];
    end

    pipe_slot #(.CW(CW), .DW(DW)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .load     (rdy[k]),
      .up_valid (up_v),
      .up_ctrl  (up_c),
      .up_data  (up_d),
      .valid    (v[k]),
      .ctrl     (s_ctrl[k]),
      .data     (s_data[k])
    );
  end

  assign out_valid = v[DEPTH-1];
  assign out_ctrl  = out_valid ? s_ctrl[DEPTH-1] : '0;
  assign out_data  = s_data[DEPTH-1];

  logic          in_xfer, out_xfer;
  logic [OW-1:0] occupancy_q, occupancy_d;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    occupancy_d = occupancy_q;
    if (flush) begin
      occupancy_d = '0;
    end else if (in_xfer && !out_xfer) begin
      occupancy_d = occupancy_q + OW'(1);
    end else if (!in_xfer && out_xfer) begin
      occupancy_d = occupancy_q - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) occupancy_q <= '0;
    else     occupancy_q <= occupancy_d;
  end

  assign occupancy = occupancy_q;

`ifdef ELASTIC_PIPE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clr_cnt) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (out_valid && !out_ready && !flush && stall_cnt_q != '1)
        stall_cnt_d = stall_cnt_q + 32'd1;
      if (flush && flush_cnt_q != '1)
        flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed bench for elastic_pipe_reg at DEPTH=3; perf counters checked
// when ELASTIC_PIPE_PERF_EN is defined.
module tb_elastic_pipe_reg;

  localparam int unsigned CW    = 15;
  localparam int unsigned DW    = 83;
  localparam int unsigned DEPTH = 3;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
`ifdef ELASTIC_PIPE_PERF_EN
  logic          clr_cnt;
  logic [31:0]   stall_cnt;
  logic [31:0]   flush_cnt;
`endif

  int checks;
  int failures;

  elastic_pipe_reg #(.CW(CW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef ELASTIC_PIPE_PERF_EN
    ,
    .clr_cnt   (clr_cnt),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic vld, input int unsigned k);
    in_valid = vld;
    in_data  = DW'(k);
    in_ctrl  = CW'(16'h0100 | k);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 15'h7FFF;
    in_data   = '1;
    out_ready = 1'b1;
`ifdef ELASTIC_PIPE_PERF_EN
    clr_cnt   = 1'b0;
`endif

    // Reset held 2 cycles with valid input offered.
    tick();
    tick();
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_ctrl",  128'(out_ctrl),  128'(0));
    chk("rst_out_data",  128'(out_data),  128'(0));
    chk("rst_occupancy", 128'(occupancy), 128'(0));
    rst = 1'b0;
    offer(1'b0, 0);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));

    // Streaming 1..4, out_ready=1: out_valid after edges 3..6.
    for (int unsigned cyc = 1; cyc <= 7; cyc++) begin
      if (cyc <= 4) offer(1'b1, cyc);
      else          offer(1'b0, 0);
      #1;
      chk("stream_in_ready", 128'(in_ready), 128'(1));
      tick();
      chk("stream_out_valid", 128'(out_valid), 128'(cyc >= 3 && cyc <= 6));
      if (cyc >= 3 && cyc <= 6) begin
        chk("stream_out_data", 128'(out_data), 128'(cyc - 2));
        chk("stream_out_ctrl", 128'(out_ctrl), 128'(16'h0100 | (cyc - 2)));
      end
    end
    chk("stream_occ_end", 128'(occupancy), 128'(0));

    // Back-pressure: 3 accepts, then in_ready falls.
    out_ready = 1'b0;
    for (int unsigned k = 1; k <= 3; k++) begin
      offer(1'b1, k);
      #1;
      chk("bp_in_ready_fill", 128'(in_ready), 128'(1));
      tick();
    end
    offer(1'b1, 4);
    #1;
    chk("bp_in_ready_full", 128'(in_ready), 128'(0));
    chk("bp_occ_full",      128'(occupancy), 128'(3));
    chk("bp_out_data_hold", 128'(out_data), 128'(1));
    tick();
    tick();
    chk("bp_stall_valid", 128'(out_valid), 128'(1));
    chk("bp_stall_data",  128'(out_data), 128'(1));
    chk("bp_stall_ctrl",  128'(out_ctrl), 128'(16'h0101));
    chk("bp_stall_occ",   128'(occupancy), 128'(3));
    chk("bp_stall_rdy",   128'(in_ready), 128'(0));

    // Release: drain in order 1..5, full shift-through keeps occupancy.
    out_ready = 1'b1;
    #1;
    chk("bp_rel_in_ready", 128'(in_ready), 128'(1));
    tick();
    chk("bp_drain_2", 128'(out_data), 128'(2));
    chk("bp_occ_a",   128'(occupancy), 128'(3));
    offer(1'b1, 5);
    tick();
    chk("bp_drain_3", 128'(out_data), 128'(3));
    chk("bp_occ_b",   128'(occupancy), 128'(3));
    offer(1'b0, 0);
    tick();
    chk("bp_drain_4", 128'(out_data), 128'(4));
    chk("bp_occ_c",   128'(occupancy), 128'(2));
    tick();
    chk("bp_drain_5", 128'(out_data), 128'(5));
    chk("bp_valid_5", 128'(out_valid), 128'(1));
    tick();
    chk("bp_drain_empty", 128'(out_valid), 128'(0));
    chk("bp_occ_empty",   128'(occupancy), 128'(0));

    // Bubble collapse: A, _, B with out_ready=0.
    out_ready = 1'b0;
    offer(1'b1, 32'hA);
    tick();
    offer(1'b0, 0);
    #1;
    chk("bub_rdy_1", 128'(in_ready), 128'(1));
    tick();
    offer(1'b1, 32'hB);
    #1;
    chk("bub_rdy_2", 128'(in_ready), 128'(1));
    tick();
    chk("bub_occ_2",  128'(occupancy), 128'(2));
    chk("bub_out_a",  128'(out_data), 128'(32'hA));
    offer(1'b0, 0);
    #1;
    chk("bub_rdy_3", 128'(in_ready), 128'(1));
    tick();
    chk("bub_occ_hold", 128'(occupancy), 128'(2));
    chk("bub_rdy_4",    128'(in_ready), 128'(1));
    offer(1'b1, 32'hC);
    tick();
    chk("bub_occ_full", 128'(occupancy), 128'(3));

    // Flush with full pipe and valid input D.
    offer(1'b1, 32'hD);
    flush = 1'b1;
    #1;
    chk("fl_in_ready", 128'(in_ready), 128'(0));
    tick();
    flush = 1'b0;
    offer(1'b0, 0);
    chk("fl_out_valid", 128'(out_valid), 128'(0));
    chk("fl_out_ctrl",  128'(out_ctrl),  128'(0));
    chk("fl_occ",       128'(occupancy), 128'(0));
    chk("fl_data_hold", 128'(out_data),  128'(32'hA));
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      chk("fl_no_ghost", 128'(out_valid), 128'(0));
    end

    // Reset mid-stream discards in-flight entries.
    offer(1'b1, 7);
    tick();
    offer(1'b1, 8);
    tick();
    rst = 1'b1;
    offer(1'b0, 0);
    tick();
    rst = 1'b0;
    chk("mrst_occ", 128'(occupancy), 128'(0));
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      chk("mrst_no_out", 128'(out_valid), 128'(0));
    end

`ifdef ELASTIC_PIPE_PERF_EN
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("perf_clr0_stall", 128'(stall_cnt), 128'(0));
    chk("perf_clr0_flush", 128'(flush_cnt), 128'(0));
    out_ready = 1'b0;
    offer(1'b1, 1);
    tick();
    tick();
    tick();
    offer(1'b0, 0);
    chk("perf_pre_stall", 128'(stall_cnt), 128'(0));
    for (int unsigned i = 0; i < 4; i++) tick();
    chk("perf_stall4", 128'(stall_cnt), 128'(4));
    flush = 1'b1;
    tick();
    tick();
    flush = 1'b0;
    chk("perf_stall_fl", 128'(stall_cnt), 128'(4));
    chk("perf_flush2",   128'(flush_cnt), 128'(2));
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("perf_clr_stall", 128'(stall_cnt), 128'(0));
    chk("perf_clr_flush", 128'(flush_cnt), 128'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
